// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: armed multi-channel ADC capture ring with pre-trigger history and streamed readback
module adc_capture_buffer #(
  parameter int NUM_CH = 2,
  parameter int SAMPLE_W = 20,
  parameter int ADDR_W = 10,
  parameter int PRETRIG = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ok_to_sample,
  input  logic [NUM_CH*SAMPLE_W-1:0] dig_in,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       trig_mode,
  input  logic [2:0]                 trig_ch,
  input  logic [SAMPLE_W-1:0]        trig_level,
  input  logic                       force_trig,
  output logic [SAMPLE_W-1:0]        rd_data,
  output logic [2:0]                 rd_ch,
  output logic                       rd_valid,
  output logic                       rd_last,
  input  logic                       rd_ready,
  output logic                       busy,
  output logic                       done
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int FW = NUM_CH * SAMPLE_W;
  localparam logic [ADDR_W:0] PRE_LAST = (ADDR_W+1)'(PRETRIG == 0 ? 0 : PRETRIG - 1);
  localparam logic [ADDR_W:0] POST_LAST = (ADDR_W+1)'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS = ADDR_W'(PRETRIG);
  localparam logic [2:0] CH_LAST = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READ, DONE} state_t;
  state_t state_q, state_d;

  logic [FW-1:0] mem [DEPTH];
  logic [FW-1:0] mem_q;
  logic [SAMPLE_W-1:0] ch_arr [8];
  logic [SAMPLE_W-1:0] q_arr [8];
  logic ok_q, se, we, trig, start, ch_ok, lvl_hit, prev_v, force_q, stall;
  logic [ADDR_W-1:0] wr_ptr, trig_addr, ra, fcnt;
  logic [ADDR_W:0] cnt;
  logic [SAMPLE_W-1:0] prev_s, cur_s;
  logic [2:0] ich, s1_ch;
  logic issue, s1_v, s1_last;

  for (genvar k = 0; k < 8; k++) begin : g_ch
    if (k < NUM_CH) begin : g_on
      assign ch_arr[k] = dig_in[k*SAMPLE_W +: SAMPLE_W];
      assign q_arr[k] = mem_q[k*SAMPLE_W +: SAMPLE_W];
    end else begin : g_off
      assign ch_arr[k] = '0;
      assign q_arr[k] = '0;
    end
  end

  assign se = ok_to_sample && !ok_q;
  assign ch_ok = 32'(trig_ch) < NUM_CH;
  assign cur_s = ch_arr[trig_ch];
  assign lvl_hit = trig_mode && ch_ok && prev_v && ($signed(prev_s) < $signed(trig_level)) && ($signed(cur_s) >= $signed(trig_level));
  assign stall = rd_valid && !rd_ready;
  assign busy = state_q == PRE || state_q == WAIT_TRIG || state_q == POST || state_q == READ;
  assign done = state_q == DONE;

  // capture state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state, frame write enable and trigger decision; abort overrides everything
  always_comb begin
    state_d = state_q;
    start = 1'b0;
    we = !abort && se && (state_q == PRE || state_q == WAIT_TRIG || state_q == POST);
    trig = we && state_q == WAIT_TRIG && (!trig_mode || lvl_hit || force_q || force_trig);
    case (state_q)
      IDLE, DONE: if (arm) begin
        start = 1'b1;
        state_d = PRETRIG == 0 ? WAIT_TRIG : PRE;
      end
      PRE: if (we && cnt == PRE_LAST) state_d = WAIT_TRIG;
      WAIT_TRIG: if (trig) state_d = POST_LAST == '0 ? READ : POST;
      POST: if (we && cnt == POST_LAST) state_d = READ;
      READ: if (rd_valid && rd_ready && rd_last) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      start = 1'b0;
    end
  end

  // write pointer, frame counter, previous trigger-channel sample and trigger latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_q <= 1'b0;
      wr_ptr <= '0;
      cnt <= '0;
      prev_s <= '0;
      prev_v <= 1'b0;
      force_q <= 1'b0;
      trig_addr <= '0;
    end else begin
      ok_q <= ok_to_sample;
      force_q <= !abort && state_q == WAIT_TRIG && !trig && (force_q || force_trig);
      if (start) begin
        wr_ptr <= '0;
        cnt <= '0;
        prev_v <= 1'b0;
      end else if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        cnt <= trig ? (ADDR_W+1)'(1) : cnt + 1'b1;
        prev_s <= cur_s;
        prev_v <= 1'b1;
      end
      if (trig) trig_addr <= wr_ptr;
    end
  end

  // frame RAM: one write port, registered read port frozen while the output stalls
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= dig_in;
    if (!stall) mem_q <= mem[ra];
  end

  // readout pipeline: issue word -> RAM read -> registered channel mux, all advancing together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0;
      fcnt <= '0;
      ich <= '0;
      issue <= 1'b0;
      s1_v <= 1'b0;
      s1_ch <= '0;
      s1_last <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
      rd_ch <= '0;
      rd_last <= 1'b0;
    end else if (abort || state_q != READ) begin
      ra <= trig_addr - PRE_OFS;
      fcnt <= '0;
      ich <= '0;
      issue <= 1'b1;
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      rd_valid <= 1'b0;
      rd_last <= 1'b0;
    end else if (!stall) begin
      s1_v <= issue;
      s1_ch <= ich;
      s1_last <= issue && fcnt == '1 && ich == CH_LAST;
      rd_valid <= s1_v;
      rd_data <= q_arr[s1_ch];
      rd_ch <= s1_ch;
      rd_last <= s1_last;
      if (issue) begin
        ich <= ich == CH_LAST ? 3'd0 : ich + 3'd1;
        if (ich == CH_LAST) begin
          ra <= ra + 1'b1;
          fcnt <= fcnt + 1'b1;
          if (fcnt == '1) issue <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: directed scenario table plus control corner sequences for adc_capture_buffer
module tb_adc_capture_buffer;
  localparam int W = 20;

  logic clk = 1'b0, rst = 1'b1, ok_to_sample = 1'b0, arm = 1'b0, abort = 1'b0;
  logic trig_mode = 1'b0, force_trig = 1'b0, rd_ready = 1'b1;
  logic [2:0] trig_ch = 3'd1;
  logic [W-1:0] trig_level = '0;
  logic [2*W-1:0] dig_in = '0;
  logic [W-1:0] rd_data, u1_data;
  logic [2:0] rd_ch, u1_ch;
  logic rd_valid, rd_last, busy, done, u1_valid, u1_last, u1_busy, u1_done;

  typedef struct {
    bit mode;
    logic [2:0] tch;
    int lvl, base, step, force_at, hi, arm_at;
    bit bp;
    int nfr, start;
  } scen_t;
  scen_t tbl [4];
  scen_t sc;

  int checks = 0, errors = 0;
  int base = 0, step = 0, pat = 0, exp_start = 0, widx = 0, vcyc = 0;
  bit mon_en = 1'b0, bp = 1'b0, hold = 1'b0;
  logic [W-1:0] hd;
  logic [2:0] hc;
  logic hl;

  always #5 clk = ~clk;

  adc_capture_buffer #(.NUM_CH(2), .SAMPLE_W(W), .ADDR_W(4), .PRETRIG(4)) u0 (
    .clk(clk), .rst(rst), .ok_to_sample(ok_to_sample), .dig_in(dig_in), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_ch(trig_ch), .trig_level(trig_level), .force_trig(force_trig),
    .rd_data(rd_data), .rd_ch(rd_ch), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy), .done(done));

  adc_capture_buffer #(.NUM_CH(2), .SAMPLE_W(W), .ADDR_W(4), .PRETRIG(0)) u1 (
    .clk(clk), .rst(rst), .ok_to_sample(ok_to_sample), .dig_in(dig_in), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_ch(trig_ch), .trig_level(trig_level), .force_trig(force_trig),
    .rd_data(u1_data), .rd_ch(u1_ch), .rd_valid(u1_valid), .rd_last(u1_last), .rd_ready(rd_ready),
    .busy(u1_busy), .done(u1_done));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sval(input int n, input int c);
    int v;
    if (c == 0) v = n;
    else if (pat == 1) v = n == 0 ? 10 : n == 1 ? -10 : 20 + n;
    else v = base + step * n;
    return W'(v);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic strobe(input int n, input int hi);
    dig_in = {sval(n, 1), sval(n, 0)};
    ok_to_sample = 1'b1;
    repeat (hi) tick();
    ok_to_sample = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (!mon_en) begin
      rd_ready = 1'b1;
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_stable", {7'd0, rd_valid, rd_last, rd_ch, rd_data}, {7'd0, 1'b1, hl, hc, hd});
      if (rd_valid) vcyc++;
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid && rd_ready) begin
        chk("word_data", 32'(rd_data), 32'(sval(exp_start + widx / 2, widx % 2)));
        chk("word_ch", 32'(rd_ch), 32'(widx % 2));
        chk("word_last", 32'(rd_last), 32'(widx == 31));
        widx++;
      end
      hold = rd_valid && !rd_ready;
      hd = rd_data;
      hc = rd_ch;
      hl = rd_last;
    end
  end

  initial begin
    tbl[0] = '{1'b0, 3'd1, 0, 0, -1, -1, 5, -1, 1'b0, 20, 0};
    tbl[1] = '{1'b1, 3'd1, 5, -100, 10, -1, 1, 14, 1'b1, 26, 7};
    tbl[2] = '{1'b1, 3'd1, 5, 0, -1, 40, 1, -1, 1'b0, 56, 36};
    tbl[3] = '{1'b1, 3'd3, 5, -100, 10, 30, 1, -1, 1'b1, 46, 26};
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_last", 32'(rd_last), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_ch", 32'(rd_ch), 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);
    for (int s = 0; s < 4; s++) begin
      sc = tbl[s];
      abort = 1'b1;
      tick();
      abort = 1'b0;
      trig_mode = sc.mode;
      trig_ch = sc.tch;
      trig_level = W'(sc.lvl);
      base = sc.base;
      step = sc.step;
      pat = 0;
      exp_start = sc.start;
      bp = sc.bp;
      widx = 0;
      vcyc = 0;
      mon_en = 1'b1;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("armed_busy", 32'(busy), 1);
      for (int n = 0; n < sc.nfr; n++) begin
        if (n == sc.force_at) begin
          force_trig = 1'b1;
          tick();
          force_trig = 1'b0;
        end
        if (n == sc.arm_at) begin
          arm = 1'b1;
          tick();
          arm = 1'b0;
        end
        strobe(n, sc.hi);
      end
      for (int i = 0; i < 3000 && !done; i++) tick();
      tick();
      chk("scen_done", 32'(done), 1);
      chk("scen_words", 32'(widx), 32);
      if (!sc.bp) chk("scen_throughput", 32'(vcyc), 32);
      mon_en = 1'b0;
    end

    abort = 1'b1;
    tick();
    abort = 1'b0;
    trig_mode = 1'b0;
    base = 0;
    step = -1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int n = 0; n < 16; n++) strobe(n, 1);
    for (int i = 0; i < 50 && !rd_valid; i++) tick();
    chk("abort_valid_seen", 32'(rd_valid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(rd_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);

    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int n = 0; n < 6; n++) strobe(n, 1);
    chk("post_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_outs", {8'd0, rd_last, rd_ch, rd_data}, 0);
    #1 rst = 1'b0;
    tick();

    trig_mode = 1'b1;
    trig_ch = 3'd1;
    trig_level = W'(5);
    pat = 1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int n = 0; n < 18; n++) strobe(n, 1);
    begin
      int k = 0;
      for (int i = 0; i < 200 && k < 32; i++) begin
        if (u1_valid) begin
          chk("p0_data", 32'(u1_data), 32'(sval(2 + k / 2, k % 2)));
          chk("p0_ch", 32'(u1_ch), 32'(k % 2));
          chk("p0_last", 32'(u1_last), 32'(k == 31));
          k++;
        end
        tick();
      end
      tick();
      chk("p0_words", 32'(k), 32);
      chk("p0_done", 32'(u1_done), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
